// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell sequenced LSB-first over
// WIDTH bits with a carry flip-flop, start/done handshake, registered results.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] a_sr, a_sr_nxt;
  logic [WIDTH-1:0] b_sr, b_sr_nxt;
  logic [WIDTH-1:0] sum_sr, sum_sr_nxt;
  logic             carry_q, carry_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             busy_nxt, done_nxt;
  logic [WIDTH-1:0] sum_nxt;
  logic             cout_nxt, ovf_nxt;
  logic             fa_s, fa_c;
  logic [WIDTH-1:0] sum_shift;

  // Single full-adder cell on the current LSBs and the stored carry
  always_comb begin
    fa_s      = a_sr[0] ^ b_sr[0] ^ carry_q;
    fa_c      = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry_q) | (b_sr[0] & carry_q);
    sum_shift = {fa_s, sum_sr[WIDTH-1:1]};
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    a_sr_nxt   = a_sr;
    b_sr_nxt   = b_sr;
    sum_sr_nxt = sum_sr;
    carry_nxt  = carry_q;
    cnt_nxt    = cnt;
    sum_nxt    = sum;
    cout_nxt   = cout;
    ovf_nxt    = ovf;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_sr_nxt  = a;
          b_sr_nxt  = b;
          carry_nxt = cin;
          cnt_nxt   = '0;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_sr_nxt = sum_shift;
        a_sr_nxt   = {1'b0, a_sr[WIDTH-1:1]};
        b_sr_nxt   = {1'b0, b_sr[WIDTH-1:1]};
        carry_nxt  = fa_c;
        if (cnt == CNT_LAST) begin
          // Final step: carry_q here is the carry into the MSB
          sum_nxt   = sum_shift;
          cout_nxt  = fa_c;
          ovf_nxt   = carry_q ^ fa_c;
          cnt_nxt   = '0;
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt == ST_RUN);
    done_nxt = (state_nxt == ST_DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nxt;
      a_sr    <= a_sr_nxt;
      b_sr    <= b_sr_nxt;
      sum_sr  <= sum_sr_nxt;
      carry_q <= carry_nxt;
      cnt     <= cnt_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      sum     <= sum_nxt;
      cout    <= cout_nxt;
      ovf     <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) with a result scoreboard.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout, ovf;

  int total = 0;
  int bad   = 0;

  // Expected {cout, ovf, sum}
  logic [W+1:0] sb_q[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference addition model
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    logic [W:0] full;
    logic       v;
    full = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
    v    = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {full[W], v, full[W-1:0]};
  endfunction

  task automatic test_reset();
    start = 1'b0; a = '0; b = '0; cin = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if ({cout, ovf, sum} !== 10'h0) begin bad++;
      $display("FAIL reset_result got=%h exp=000", {cout, ovf, sum}); end
    // rst wins over start on the same edge
    start = 1'b1; a = 8'h11; b = 8'h22;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_priority busy got=%b exp=0", busy); end
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_hold busy got=%b exp=0", busy); end
  endtask

  // One operation from IDLE: checks busy span, latency and result
  task automatic run_op(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci);
    int k;
    int busy_cnt;
    logic [W+1:0] exp_r;
    start = 1'b1; a = x; b = y; cin = ci;
    sb_q.push_back(model(x, y, ci));
    @(negedge clk);
    start = 1'b0; a = ~x; b = ~y; cin = ~ci;
    busy_cnt = 0;
    k = 0;
    while (k < 20 && done !== 1'b1) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      k++;
    end
    total++; if (k !== W) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", nm, k, W); end
    total++; if (busy_cnt !== W) begin bad++; $display("FAIL %s busy_cycles got=%0d exp=%0d", nm, busy_cnt, W); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_with_done got=%b exp=0", nm, busy); end
    if (done === 1'b1 && sb_q.size() > 0) begin
      exp_r = sb_q.pop_front();
      total++; if ({cout, ovf, sum} !== exp_r) begin bad++;
        $display("FAIL %s result got cout=%b ovf=%b sum=%h exp cout=%b ovf=%b sum=%h",
                 nm, cout, ovf, sum, exp_r[W+1], exp_r[W], exp_r[W-1:0]); end
    end else begin
      sb_q.delete();
    end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL %s done_width got=%b exp=0", nm, done); end
  endtask

  task automatic test_vectors();
    run_op("v35_4a", 8'h35, 8'h4A, 1'b0);
    run_op("vff_01", 8'hFF, 8'h01, 1'b0);
    run_op("v7f_01", 8'h7F, 8'h01, 1'b0);
    run_op("v80_80", 8'h80, 8'h80, 1'b1);
  endtask

  // start held high, operands randomised every cycle
  task automatic test_back_to_back();
    logic [W+1:0] held;
    logic [W+1:0] exp_r;
    logic         exp_done, exp_busy;
    held = {cout, ovf, sum};
    for (int i = 0; i <= 36; i++) begin
      if (i > 0) begin
        exp_done = (i % 9 == 0);
        exp_busy = !exp_done;
        total++; if (done !== exp_done) begin bad++; $display("FAIL b2b_done i=%0d got=%b exp=%b", i, done, exp_done); end
        total++; if (busy !== exp_busy) begin bad++; $display("FAIL b2b_busy i=%0d got=%b exp=%b", i, busy, exp_busy); end
        if (exp_done) begin
          if (sb_q.size() == 0) begin
            bad++; total++; $display("FAIL b2b_queue i=%0d got=empty exp=entry", i);
          end else begin
            exp_r = sb_q.pop_front();
            held  = exp_r;
          end
        end
        total++; if ({cout, ovf, sum} !== held) begin bad++;
          $display("FAIL b2b_result i=%0d got=%h exp=%h", i, {cout, ovf, sum}, held); end
      end
      if (i == 36) begin
        start = 1'b0;
      end else begin
        start = 1'b1;
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
        if (i % 9 == 0) sb_q.push_back(model(a, b, cin));
      end
      @(negedge clk);
    end
    total++; if (sb_q.size() != 0) begin bad++; $display("FAIL b2b_leftover got=%0d exp=0", sb_q.size()); end
    @(negedge clk);
  endtask

  // Reset during RUN discards the operation
  task automatic test_reset_mid_run();
    int seen;
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if ({busy, done, cout, ovf, sum} !== 12'h0) begin bad++;
      $display("FAIL midrun_reset got busy=%b done=%b cout=%b ovf=%b sum=%h exp all 0",
               busy, done, cout, ovf, sum); end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      @(negedge clk);
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrun_no_done got=%0d exp=0", seen); end
    run_op("after_rst", 8'h01, 8'h02, 1'b0);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute timeout
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller. It sequences one internally instantiated 1-bit full-adder cell over the WIDTH bits of two operands, LSB first, using a carry flip-flop between steps. It takes a start/done handshake from the surrounding datapath and returns a registered sum, carry-out and signed overflow. It trades WIDTH cycles of latency for the area of a single full-adder cell.

## Interface

Parameters:
- WIDTH, default 8: operand and sum width in bits; legal range 2..32.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request an addition; sampled only in IDLE or DONE.
- a, input, WIDTH: operand A; captured on an accepted start.
- b, input, WIDTH: operand B; captured on an accepted start.
- cin, input, 1: carry-in; captured on an accepted start.
- busy, output, 1: high while in RUN.
- done, output, 1: one-cycle pulse; sum, cout and ovf are valid from this cycle.
- sum, output, WIDTH: result; holds until the next completion or reset.
- cout, output, 1: carry out of bit WIDTH-1.
- ovf, output, 1: signed overflow, i.e. carry into MSB XOR carry out of MSB.

## Operation

- Clock and reset: one clock; reset is synchronous and active-high.
- States and their transitions:
  - IDLE: wait for start.
  - RUN: perform one full-adder step per cycle.
  - DONE: one cycle; asserts done.
- IDLE:
  - start=1: capture a and b into shift registers, carry_q<=cin, cnt<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - Full adder computes (s, c) from a_sr[0], b_sr[0] and carry_q.
  - sum_sr <= {s, sum_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right by one.
  - carry_q <= c; cnt <= cnt+1.
  - On the step where cnt==WIDTH-1:
    - Load the sum output from the final shifted value.
    - cout <= c.
    - ovf <= carry_q XOR c, where carry_q is the carry into the MSB at this step.
    - Go to DONE.
- DONE:
  - done=1, busy=0.
  - start=1: accept a new operation exactly as in IDLE and go to RUN (back-to-back).
  - Otherwise go to IDLE.
- start while in RUN is ignored. No queuing; the in-flight operation is unaffected.
- a, b and cin are don't-care except on the accepting edge. Changing them mid-RUN has no effect.
- Arithmetic:
  - {cout, sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1).
  - ovf is set iff a and b have the same sign and sum has the opposite sign (two's complement, with cin included).
- sum, cout and ovf are written only at the final RUN step. They keep the previous result during RUN.
- cnt is ceil(log2(WIDTH)) bits wide and never exceeds WIDTH-1.

## Timing

- Reset: rst=1 at an edge forces the following, regardless of state (including mid-RUN):
  - state=IDLE, busy=0, done=0.
  - sum=0, cout=0, ovf=0.
  - cnt=0, carry_q=0.
  - The in-flight operation is discarded and done is not generated for it.
- rst has priority over start on the same edge.
- Latency:
  - start accepted at edge E, then busy=1 after E.
  - RUN occupies edges E+1 .. E+WIDTH.
  - After edge E+WIDTH: state=DONE, done=1, busy=0, results valid.
  - Start-to-done = WIDTH cycles.
- Throughput:
  - Back-to-back via start in DONE gives one result per WIDTH+1 cycles.
  - Via IDLE it is WIDTH+2 or more cycles.
- done is high for exactly one cycle per completed operation. It is never high in the same cycle as busy.
- All outputs are registered; there is no combinational path from the inputs to any output.

## Test plan

- Reset, then 0x35+0x4A, cin=0, WIDTH=8, start for 1 cycle:
  - busy for 8 cycles.
  - done pulse exactly 8 cycles after the accepting edge.
  - sum=0x7F, cout=0, ovf=0.
- 0xFF+0x01, cin=0: sum=0x00, cout=1, ovf=0.
- 0x7F+0x01, cin=0: sum=0x80, cout=0, ovf=1.
- 0x80+0x80, cin=1: sum=0x01, cout=1, ovf=1.
- Hold start high continuously with operands changed every cycle:
  - Only the operands present at the accepting edges are used.
  - Operations run back-to-back with a period of 9 cycles.
  - The result is held between done pulses.
- Start 0x12+0x34, then assert rst for 1 cycle at the 3rd RUN cycle:
  - All outputs go to 0, no done pulse occurs, and the block is in IDLE.
  - A following start of 0x01+0x02 yields sum=0x03 after 8 cycles.
